// File: rtl/mips_pkg.sv
// Shared encodings for the MIPS decode stage: opcode/funct values, ALU
// operation codes, scoreboard width default and the decoded-control bundle.
package mips_pkg;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ADDIU = 6'h09;
   localparam logic [5:0] OP_BNE   = 6'h05;

   localparam logic [5:0] FN_ADD   = 6'h20;
   localparam logic [5:0] FN_ADDU  = 6'h21;

   localparam logic [11:0] ALUOP_NONE = 12'h000;
   localparam logic [11:0] ALUOP_ADD  = 12'h001;

   localparam int SB_W_DEF = 2;

   // Everything the decoder derives from the instruction word alone.
   typedef struct packed {
      logic [31:0] imm;
      logic [11:0] aluop;
      logic        alu_src;
      logic        branch;
      logic [4:0]  dst;
      logic        reg_write;
      logic        illegal;
   } ctrl_t;

endpackage

// File: rtl/decode_stage_regfile.sv
// 32x32 architectural register file: two combinational read ports with
// write-through bypass, one write port, $0 hardwired to zero.
module decode_stage_regfile (
   input  logic        clk,
   input  logic        rst,
   input  logic        we,
   input  logic [4:0]  waddr,
   input  logic [31:0] wdata,
   input  logic [4:0]  raddr_a,
   input  logic [4:0]  raddr_b,
   output logic [31:0] rdata_a,
   output logic [31:0] rdata_b
);

   logic [31:0] mem [32];

   // Storage update: clear on reset, otherwise accept writeback (never to $0).
   always_ff @(posedge clk) begin
      if (rst) begin
         // NOTE: this array is reset because architectural state must come up
         // as zero; that rules out mapping it onto a RAM macro. Sequential state
         // uses <= so every flop samples pre-edge values regardless of order.
         for (int i = 0; i < 32; i++) mem[i] <= '0;
      end else if (we && waddr != 5'd0) begin
         mem[waddr] <= wdata;
      end
   end

   // A write in flight this cycle is visible to a same-cycle read.
   assign rdata_a = (raddr_a == 5'd0)                 ? 32'd0 :
                    (we && waddr == raddr_a)          ? wdata : mem[raddr_a];
   assign rdata_b = (raddr_b == 5'd0)                 ? 32'd0 :
                    (we && waddr == raddr_b)          ? wdata : mem[raddr_b];

endmodule

// File: rtl/decode_stage.sv
// ID stage: decodes fetched words, reads operands, tracks in-flight register
// writes in a per-register scoreboard and stalls issue on RAW hazards, then
// registers the execute controls in the ID/EX pipeline register.
module decode_stage
   import mips_pkg::*;
#(
   parameter int SB_W = SB_W_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_instr,
   input  logic        flush,
   input  logic        wb_we,
   input  logic [4:0]  wb_addr,
   input  logic [31:0] wb_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] rs,
   output logic [31:0] rt,
   output logic [31:0] imm,
   output logic [11:0] aluop,
   output logic        alu_src,
   output logic        branch,
   output logic [4:0]  dst,
   output logic        reg_write,
   output logic        illegal
);

   localparam logic [SB_W-1:0] SB_ZERO = '0;
   localparam logic [SB_W-1:0] SB_ONE  = {{(SB_W-1){1'b0}}, 1'b1};
   localparam logic [SB_W-1:0] SB_MAX  = '1;

   logic [5:0]  op;
   logic [5:0]  funct;
   logic [4:0]  f_rs;
   logic [4:0]  f_rt;
   logic [4:0]  f_rd;

   ctrl_t       dec;
   logic        use_rs;
   logic        use_rt;

   logic [31:0] rd_a;
   logic [31:0] rd_b;

   logic [SB_W-1:0] sb_cnt [32];
   logic [31:0]     sb_inc;
   logic [31:0]     sb_dec;
   logic [SB_W-1:0] rs_eff;
   logic [SB_W-1:0] rt_eff;
   logic [SB_W-1:0] dst_eff;

   logic        hazard;
   logic        fire;

   assign op    = in_instr[31:26];
   assign f_rs  = in_instr[25:21];
   assign f_rt  = in_instr[20:16];
   assign f_rd  = in_instr[15:11];
   assign funct = in_instr[5:0];

   decode_stage_regfile u_regfile (
      .clk     (clk),
      .rst     (rst),
      .we      (wb_we),
      .waddr   (wb_addr),
      .wdata   (wb_data),
      .raddr_a (f_rs),
      .raddr_b (f_rt),
      .rdata_a (rd_a),
      .rdata_b (rd_b)
   );

   // Instruction decode: controls plus which source fields are really read.
   always_comb begin
      // NOTE: every variable gets a default before any branch, so no path can
      // leave one unassigned and infer a latch.
      dec       = '0;
      dec.aluop = ALUOP_NONE;
      dec.imm   = {{16{in_instr[15]}}, in_instr[15:0]};
      use_rs    = 1'b0;
      use_rt    = 1'b0;
      if (in_instr != 32'd0) begin
         use_rs = 1'b1;
         use_rt = (op == OP_RTYPE);
         if (op == OP_RTYPE && (funct == FN_ADD || funct == FN_ADDU)) begin
            dec.aluop     = ALUOP_ADD;
            dec.dst       = f_rd;
            dec.reg_write = 1'b1;
         end else if (op == OP_ADDI || op == OP_ADDIU) begin
            dec.aluop     = ALUOP_ADD;
            dec.alu_src   = 1'b1;
            dec.dst       = f_rt;
            dec.reg_write = 1'b1;
         end else if (op == OP_BNE && f_rt == 5'd0) begin
            dec.aluop     = ALUOP_ADD;
            dec.alu_src   = 1'b1;
            dec.branch    = 1'b1;
         end else begin
            dec.illegal   = 1'b1;
         end
      end
   end

   // Writeback retires one pending write; an idle counter is never decremented.
   always_comb begin
      sb_dec = '0;
      if (wb_we && wb_addr != 5'd0 && sb_cnt[wb_addr] != SB_ZERO)
         sb_dec[wb_addr] = 1'b1;
   end

   // Hazard check against counts as they will stand after this cycle's writeback.
   always_comb begin
      rs_eff  = sb_cnt[f_rs]    - (sb_dec[f_rs]    ? SB_ONE : SB_ZERO);
      rt_eff  = sb_cnt[f_rt]    - (sb_dec[f_rt]    ? SB_ONE : SB_ZERO);
      dst_eff = sb_cnt[dec.dst] - (sb_dec[dec.dst] ? SB_ONE : SB_ZERO);
      hazard  = (use_rs && rs_eff != SB_ZERO) ||
                (use_rt && rt_eff != SB_ZERO) ||
                (dec.reg_write && dec.dst != 5'd0 && dst_eff == SB_MAX);
   end

   // in_ready deliberately ignores flush so fetch sees a stable handshake.
   assign in_ready = (!out_valid || out_ready) && !hazard;
   assign fire     = in_valid && in_ready && !flush;

   // Issue of a register-writing instruction claims its destination.
   always_comb begin
      sb_inc = '0;
      if (fire && dec.reg_write && dec.dst != 5'd0)
         sb_inc[dec.dst] = 1'b1;
   end

   // Scoreboard counters: simultaneous claim and retire cancel out.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 32; i++) sb_cnt[i] <= '0;
      end else begin
         for (int i = 0; i < 32; i++) begin
            if (sb_inc[i] && !sb_dec[i])
               sb_cnt[i] <= sb_cnt[i] + SB_ONE;
            else if (sb_dec[i] && !sb_inc[i])
               sb_cnt[i] <= sb_cnt[i] - SB_ONE;
         end
      end
   end

   // ID/EX register: load on issue, otherwise drain; data holds after drain.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         rs        <= '0;
         rt        <= '0;
         imm       <= '0;
         aluop     <= ALUOP_NONE;
         alu_src   <= 1'b0;
         branch    <= 1'b0;
         dst       <= '0;
         reg_write <= 1'b0;
         illegal   <= 1'b0;
      end else if (fire) begin
         out_valid <= 1'b1;
         rs        <= rd_a;
         rt        <= rd_b;
         imm       <= dec.imm;
         aluop     <= dec.aluop;
         alu_src   <= dec.alu_src;
         branch    <= dec.branch;
         dst       <= dec.dst;
         reg_write <= dec.reg_write;
         illegal   <= dec.illegal;
      end else if (out_valid && out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: a reference decoder and register file
// predict each ID/EX record when a word is accepted; records are checked
// every cycle they are presented and retired when execute consumes them.
module tb_decode_stage;

   typedef struct packed {
      logic [31:0] rs;
      logic [31:0] rt;
      logic [31:0] imm;
      logic [11:0] aluop;
      logic        alu_src;
      logic        branch;
      logic [4:0]  dst;
      logic        reg_write;
      logic        illegal;
   } rec_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_instr;
   logic        flush;
   logic        wb_we;
   logic [4:0]  wb_addr;
   logic [31:0] wb_data;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] rs;
   logic [31:0] rt;
   logic [31:0] imm;
   logic [11:0] aluop;
   logic        alu_src;
   logic        branch;
   logic [4:0]  dst;
   logic        reg_write;
   logic        illegal;

   int   total = 0;
   int   bad   = 0;
   rec_t exp_q[$];
   logic [31:0] ref_rf [32];
   logic mon_en = 1'b0;
   logic last_ready;
   logic last_acc;

   always #5 clk = ~clk;

   decode_stage dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_instr  (in_instr),
      .flush     (flush),
      .wb_we     (wb_we),
      .wb_addr   (wb_addr),
      .wb_data   (wb_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .rs        (rs),
      .rt        (rt),
      .imm       (imm),
      .aluop     (aluop),
      .alu_src   (alu_src),
      .branch    (branch),
      .dst       (dst),
      .reg_write (reg_write),
      .illegal   (illegal)
   );

   function automatic logic [31:0] ref_read(input logic [4:0] a);
      if (a == 5'd0) return 32'd0;
      if (wb_we && wb_addr == a) return wb_data;
      return ref_rf[a];
   endfunction

   function automatic rec_t model(input logic [31:0] w);
      rec_t r;
      logic [5:0] op;
      logic [5:0] fn;
      op = w[31:26];
      fn = w[5:0];
      r     = '0;
      r.rs  = ref_read(w[25:21]);
      r.rt  = ref_read(w[20:16]);
      r.imm = {{16{w[15]}}, w[15:0]};
      case (1'b1)
         (w == 32'd0): ;
         (op == 6'h00 && (fn == 6'h20 || fn == 6'h21)): begin
            r.aluop = 12'h001; r.dst = w[15:11]; r.reg_write = 1'b1;
         end
         (op == 6'h08 || op == 6'h09): begin
            r.aluop = 12'h001; r.alu_src = 1'b1; r.dst = w[20:16]; r.reg_write = 1'b1;
         end
         (op == 6'h05 && w[20:16] == 5'd0): begin
            r.aluop = 12'h001; r.alu_src = 1'b1; r.branch = 1'b1;
         end
         default: r.illegal = 1'b1;
      endcase
      return r;
   endfunction

   // One clock: observe at the falling edge, then advance past the rising edge.
   task automatic cycle();
      rec_t act;
      rec_t exp;
      @(negedge clk);
      last_ready = in_ready;
      last_acc   = 1'b0;
      if (rst) begin
         exp_q.delete();
         for (int i = 0; i < 32; i++) ref_rf[i] = 32'd0;
      end else begin
         if (mon_en && out_valid !== 1'b0) begin
            total++;
            if (exp_q.size() == 0) begin
               bad++;
               $display("FAIL unexpected_output out_valid=%b with nothing pending", out_valid);
            end else begin
               exp = exp_q[0];
               act = {rs, rt, imm, aluop, alu_src, branch, dst, reg_write, illegal};
               if (!exp.reg_write) act.dst = 5'd0;
               if (act !== exp) begin
                  bad++;
                  $display("FAIL idex_record got=%h want=%h", act, exp);
               end
               if (out_ready) void'(exp_q.pop_front());
            end
         end
         if (in_valid && in_ready && !flush) begin
            last_acc = 1'b1;
            exp_q.push_back(model(in_instr));
         end
         if (wb_we && wb_addr != 5'd0) ref_rf[wb_addr] = wb_data;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [31:0] w);
      int n;
      n        = 0;
      in_valid = 1'b1;
      in_instr = w;
      do begin
         cycle();
         n++;
      end while (!last_acc && n < 20);
      in_valid = 1'b0;
      total++;
      if (!last_acc) begin
         bad++;
         $display("FAIL send_timeout instr=%h accepted=0 required=1 after %0d cycles", w, n);
      end
   endtask

   task automatic wb(input logic [4:0] a, input logic [31:0] d);
      wb_we = 1'b1; wb_addr = a; wb_data = d;
      cycle();
      wb_we = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; in_instr = '0; flush = 1'b0;
      wb_we = 1'b0; wb_addr = '0; wb_data = '0; out_ready = 1'b1;
      cycle();
      cycle();
      rst    = 1'b0;
      mon_en = 1'b1;
      total++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         bad++;
         $display("FAIL reset_handshake out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
      end
      total++;
      if ({rs, rt, imm, aluop, alu_src, branch, dst, reg_write, illegal} !== '0) begin
         bad++;
         $display("FAIL reset_outputs rs=%h rt=%h imm=%h aluop=%h want all zero", rs, rt, imm, aluop);
      end
   endtask

   task automatic test_addi();
      send(32'h2001_0005);
      total++;
      if (out_valid !== 1'b1 || imm !== 32'd5 || aluop !== 12'h001 || alu_src !== 1'b1 ||
          dst !== 5'd1 || reg_write !== 1'b1 || rs !== 32'd0) begin
         bad++;
         $display("FAIL addi_fields v=%b imm=%h aluop=%h src=%b dst=%0d rw=%b rs=%h", out_valid, imm, aluop, alu_src, dst, reg_write, rs);
      end
   endtask

   task automatic test_raw_stall();
      in_valid = 1'b1;
      in_instr = 32'h0021_1020;              // ADD $2,$1,$1
      for (int i = 0; i < 2; i++) begin
         cycle();
         total++;
         if (last_ready !== 1'b0) begin
            bad++;
            $display("FAIL raw_stall in_ready=%b want 0", last_ready);
         end
      end
      wb_we = 1'b1; wb_addr = 5'd1; wb_data = 32'd5;
      cycle();
      wb_we = 1'b0; in_valid = 1'b0;
      total++;
      if (last_acc !== 1'b1) begin
         bad++;
         $display("FAIL raw_release accepted=%b want 1 on writeback cycle", last_acc);
      end
      total++;
      if (rs !== 32'd5 || rt !== 32'd5) begin
         bad++;
         $display("FAIL raw_operands rs=%h rt=%h want 5/5", rs, rt);
      end
   endtask

   task automatic test_saturate();
      in_valid = 1'b1;
      for (int k = 1; k <= 3; k++) begin
         in_instr = 32'h2003_0000 | k;
         cycle();
         total++;
         if (last_acc !== 1'b1) begin
            bad++;
            $display("FAIL sat_fill%0d accepted=%b want 1", k, last_acc);
         end
      end
      in_instr = 32'h2003_0004;
      cycle();
      total++;
      if (last_ready !== 1'b0) begin
         bad++;
         $display("FAIL sat_stall in_ready=%b want 0", last_ready);
      end
      wb_we = 1'b1; wb_addr = 5'd3; wb_data = 32'h33;
      cycle();
      wb_we = 1'b0;
      total++;
      if (last_acc !== 1'b1) begin
         bad++;
         $display("FAIL sat_same_cycle accepted=%b want 1", last_acc);
      end
      in_instr = 32'h2003_0005;            // counter should still be full
      cycle();
      total++;
      if (last_ready !== 1'b0) begin
         bad++;
         $display("FAIL sat_inc_dec_cancel in_ready=%b want 0", last_ready);
      end
      in_valid = 1'b0;
      for (int k = 0; k < 4; k++) wb(5'd3, 32'h100 + k);   // last one hits a zero count
      send(32'h2003_0006);
      wb(5'd3, 32'h200);
   endtask

   task automatic test_branch_flush();
      cycle();
      out_ready = 1'b0;
      send(32'h1480_FFFE);                 // BNE $4,$0,-2
      total++;
      if (branch !== 1'b1 || imm !== 32'hFFFF_FFFE || reg_write !== 1'b0) begin
         bad++;
         $display("FAIL bne_fields branch=%b imm=%h rw=%b want 1/fffffffe/0", branch, imm, reg_write);
      end
      in_valid = 1'b1; in_instr = 32'h2005_0007; flush = 1'b1; out_ready = 1'b1;
      cycle();
      flush = 1'b0; in_valid = 1'b0;
      total++;
      if (last_ready !== 1'b1 || last_acc !== 1'b0) begin
         bad++;
         $display("FAIL flush_drop in_ready=%b accepted=%b want 1/0", last_ready, last_acc);
      end
      total++;
      if (out_valid !== 1'b0) begin
         bad++;
         $display("FAIL flush_drain out_valid=%b want 0", out_valid);
      end
      in_valid = 1'b1; in_instr = 32'h00A5_3020;   // ADD $6,$5,$5: $5 must be idle
      cycle();
      in_valid = 1'b0;
      total++;
      if (last_acc !== 1'b1) begin
         bad++;
         $display("FAIL flush_sb_untouched accepted=%b want 1", last_acc);
      end
   endtask

   task automatic test_backpressure();
      logic [31:0] words [4];
      int idx;
      words[0] = 32'h2008_0001; words[1] = 32'h2009_0002;
      words[2] = 32'h200A_0003; words[3] = 32'h200B_0004;
      cycle();
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_instr  = words[0];
      cycle();
      total++;
      if (last_acc !== 1'b1) begin
         bad++;
         $display("FAIL bp_first accepted=%b want 1", last_acc);
      end
      in_instr = words[1];
      for (int i = 0; i < 3; i++) begin
         cycle();
         total++;
         if (last_ready !== 1'b0 || last_acc !== 1'b0) begin
            bad++;
            $display("FAIL bp_hold in_ready=%b accepted=%b want 0/0", last_ready, last_acc);
         end
      end
      out_ready = 1'b1;
      idx = 1;
      for (int n = 0; n < 10 && idx < 4; n++) begin
         cycle();
         if (last_acc) begin
            idx++;
            if (idx < 4) in_instr = words[idx];
         end
      end
      in_valid = 1'b0;
      total++;
      if (idx != 4) begin
         bad++;
         $display("FAIL bp_stream accepted=%0d want 4", idx);
      end
      cycle();
      cycle();
      total++;
      if (exp_q.size() != 0 || out_valid !== 1'b0) begin
         bad++;
         $display("FAIL bp_drain pending=%0d out_valid=%b want 0/0", exp_q.size(), out_valid);
      end
   endtask

   task automatic test_illegal_r0();
      send(32'hFC00_0000);
      total++;
      if (illegal !== 1'b1 || reg_write !== 1'b0 || aluop !== 12'h000) begin
         bad++;
         $display("FAIL illegal_fields illegal=%b rw=%b aluop=%h want 1/0/000", illegal, reg_write, aluop);
      end
      wb_we = 1'b1; wb_addr = 5'd0; wb_data = 32'hDEAD;
      send(32'h0000_6021);                 // ADDU $12,$0,$0 alongside the $0 write
      wb_we = 1'b0;
      total++;
      if (rs !== 32'd0 || rt !== 32'd0) begin
         bad++;
         $display("FAIL r0_same_cycle rs=%h rt=%h want 0/0", rs, rt);
      end
      send(32'h0000_6021);
      total++;
      if (rs !== 32'd0 || rt !== 32'd0) begin
         bad++;
         $display("FAIL r0_later rs=%h rt=%h want 0/0", rs, rt);
      end
      send(32'h0000_0000);
      total++;
      if (aluop !== 12'h000 || reg_write !== 1'b0 || illegal !== 1'b0) begin
         bad++;
         $display("FAIL nop_fields aluop=%h rw=%b illegal=%b want 000/0/0", aluop, reg_write, illegal);
      end
   endtask

   task automatic test_reset_mid_stall();
      cycle();
      out_ready = 1'b0;
      send(32'h200F_0009);
      in_valid = 1'b1;
      in_instr = 32'h0026_7020;            // ADD $14,$1,$6: $6 still pending
      cycle();
      total++;
      if (last_ready !== 1'b0) begin
         bad++;
         $display("FAIL pre_reset_stall in_ready=%b want 0", last_ready);
      end
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      total++;
      if (out_valid !== 1'b0 || {rs, rt, imm, dst, reg_write} !== '0) begin
         bad++;
         $display("FAIL mid_reset out_valid=%b rs=%h imm=%h want 0/0/0", out_valid, rs, imm);
      end
      out_ready = 1'b1;
      cycle();
      in_valid = 1'b0;
      total++;
      if (last_acc !== 1'b1) begin
         bad++;
         $display("FAIL post_reset_sb accepted=%b want 1", last_acc);
      end
      total++;
      if (rs !== 32'd0) begin
         bad++;
         $display("FAIL post_reset_rf rs=%h want 0", rs);
      end
      cycle();
      cycle();
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL final_queue pending=%0d want 0", exp_q.size());
      end
   endtask

   initial begin
      test_reset();
      test_addi();
      test_raw_stall();
      test_saturate();
      test_branch_flush();
      test_backpressure();
      test_illegal_r0();
      test_reset_mid_stall();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
